drum_column_solver: RTL and testbench
=====================================

# drum_column_solver

Time-steps one full column of the drum mesh in place: ROWS nodes held in on-chip RAM, one node updated per clock with the damped discrete wave equation. One instance per mesh column; all columns share `step_start` and run in lockstep, so each column exchanges per-row current values with its left and right neighbours every cycle. A top-level controller loads initial conditions, issues steps, and reads the audio tap.

## Interface
Parameters:
- WIDTH, 18: signed node value width (two's complement, fixed point).
- ROWS, 32: nodes per column (≥ 3).
- RHO_SHIFT, 4: rho = 2^-RHO_SHIFT.
- DAMP_PREV_SHIFT, 12: u_prev damping term shift.
- DAMP_OUT_SHIFT, 13: output damping term shift.
- TAP_ROW, ROWS/2: row copied to `tap_out`.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- init_we  in  1  write initial condition (honoured only when idle).
- init_addr  in  $clog2(ROWS)  row to initialise.
- init_u, init_u_prev  in  WIDTH  values written to u / u_prev RAMs.
- step_start  in  1  start one time step (honoured only when idle).
- busy  out  1  step in progress.
- step_done  out  1  one-cycle pulse: step complete.
- u_row_out  out  WIDTH  old u of the row being updated (to neighbours).
- left_u, right_u  in  WIDTH  neighbours' old u of the same row, same cycle (edge columns tie to 0).
- tap_out  out  WIDTH  registered new u[TAP_ROW].

## Operation
- States: IDLE → LOAD0 (read row 0) → LOAD1 (read row 1, capture row 0) → RUN (row i = 0..ROWS-1) → DONE → IDLE.
- Window registers hold old u[i-1], u[i], u[i+1]; u[-1] and u[ROWS] read as 0 (clamped edge). In RUN row i, issue a read of row i+2 (none past ROWS-1).
- Update: lap = up + down + left + right − 4u, computed in WIDTH+3 bits; r = lap >>> RHO_SHIFT; t = r + 2u − u_prev + (u_prev >>> DAMP_PREV_SHIFT); u_next = t − (t >>> DAMP_OUT_SHIFT). All shifts are arithmetic. Without the clamp macro, t and u_next wrap to WIDTH bits.
- In RUN row i: write u_next to u RAM[i] and old u[i] to u_prev RAM[i]. Old u[i] is already held in the window, so later rows see old values only.
- tap_out updates on the cycle row TAP_ROW is written.
- step_start while busy: ignored. init_we while busy: ignored (no RAM write).
- Reset: state IDLE; busy=0, step_done=0, u_row_out=0, tap_out=0. RAM contents are not cleared. A reset mid-step aborts the step and leaves rows already written at their new values.

## Timing
- step_start sampled in cycle k → busy=1 from k+1 through k+ROWS+2; RUN occupies cycles k+3..k+ROWS+2; step_done=1 in cycle k+ROWS+3 only; a new step is accepted from k+ROWS+4.
- init_we: 1-cycle write, visible to a step started on the next cycle.
- u_row_out is valid during RUN only; it holds 0 otherwise.
- RAM read latency is 1 cycle; the update path is combinational within the RUN cycle.

## Configuration
- DRUM_CLAMP_EN defined: t and u_next saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1] instead of wrapping.
- Undefined: two's-complement wrap at WIDTH bits.

## Structure
- drum_pkg: solver state enum typedef, default WIDTH/ROWS constants, and the saturate helper function.
- Sub-module drum_node_update: the combinational update arithmetic, including the clamp option. The column block owns the FSM, RAMs, window and tap.

## Test plan
All scenarios use WIDTH=18, ROWS=4, TAP_ROW=1, left/right tied to 0 unless stated.
- All RAMs zero, step_start at cycle k → all rows stay 0; step_done exactly at k+7; busy high k+1..k+6.
- u[1]=u_prev[1]=16384, all others 0, one step → u[1]=12291, u[0]=1024, u[2]=1024, u[3]=0; u_prev[1]=16384; tap_out=12291.
- All u=131071, u_prev=0, left/right=131071 → row 1: without DRUM_CLAMP_EN u_next=−1; with DRUM_CLAMP_EN u_next=131056.
- step_start and init_we pulsed mid-step → no second step, no RAM write, single step_done.
- rst at cycle k+4 of a step → next cycle busy=0, tap_out=0, no step_done; row 0 holds its new value and rows 2–3 their old values; a fresh step then runs normally.

Source files
------------

// File: rtl/drum_pkg.sv
// drum_pkg: shared types and helpers for the drum mesh column solver.
//   solver_state_e : column solver FSM states
//   DefaultWidth   : default signed node value width
//   DefaultRows    : default nodes per column
//   saturate()     : clamp a signed value into a w-bit two's-complement range
package drum_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad0,
        StLoad1,
        StRun,
        StDone
    } solver_state_e;

    localparam int unsigned DefaultWidth = 18;
    localparam int unsigned DefaultRows  = 32;

    function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                    input int unsigned        w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/drum_node_update.sv
// drum_node_update: combinational damped wave-equation update of one mesh node.
//   up_i, down_i, left_i, right_i : old u of the four neighbours
//   u_i, u_prev_i                 : old u and u_prev of the node
//   u_next_o                      : new u of the node
// Build option DRUM_CLAMP_EN: t and u_next saturate instead of wrapping at WIDTH bits.
module drum_node_update
    import drum_pkg::*;
#(
    parameter int unsigned WIDTH           = DefaultWidth,
    parameter int unsigned RHO_SHIFT       = 4,
    parameter int unsigned DAMP_PREV_SHIFT = 12,
    parameter int unsigned DAMP_OUT_SHIFT  = 13
) (
    input  logic signed [WIDTH-1:0] up_i,
    input  logic signed [WIDTH-1:0] down_i,
    input  logic signed [WIDTH-1:0] left_i,
    input  logic signed [WIDTH-1:0] right_i,
    input  logic signed [WIDTH-1:0] u_i,
    input  logic signed [WIDTH-1:0] u_prev_i,
    output logic signed [WIDTH-1:0] u_next_o
);

    localparam int unsigned LW = WIDTH + 3;  // laplacian width
    localparam int unsigned TW = WIDTH + 4;  // headroom for r + 2u - u_prev + damping
    localparam int unsigned OW = WIDTH + 1;  // headroom for t - (t >>> shift)

    logic signed [LW-1:0]    lap;
    logic signed [LW-1:0]    r;
    logic signed [TW-1:0]    t_wide;
    logic signed [WIDTH-1:0] t;
    logic signed [OW-1:0]    o_wide;

    always_comb begin
        lap    = LW'(up_i) + LW'(down_i) + LW'(left_i) + LW'(right_i) - (LW'(u_i) <<< 2);
        r      = lap >>> RHO_SHIFT;
        t_wide = TW'(r) + (TW'(u_i) <<< 1) - TW'(u_prev_i)
               + TW'(u_prev_i >>> DAMP_PREV_SHIFT);
`ifdef DRUM_CLAMP_EN
        t        = WIDTH'(saturate(32'(t_wide), WIDTH));
        o_wide   = OW'(t) - OW'(t >>> DAMP_OUT_SHIFT);
        u_next_o = WIDTH'(saturate(32'(o_wide), WIDTH));
`else
        t        = WIDTH'(t_wide);
        o_wide   = OW'(t) - OW'(t >>> DAMP_OUT_SHIFT);
        u_next_o = WIDTH'(o_wide);
`endif
    end

endmodule

// File: rtl/drum_column_solver.sv
// drum_column_solver: time-steps one drum mesh column in place, one row per clock.
//   clk, rst                  : clock, synchronous active-high reset
//   init_we/init_addr/init_u/init_u_prev : initial-condition write (idle only)
//   step_start                : start one time step (idle only)
//   busy, step_done           : step in progress / one-cycle completion pulse
//   u_row_out                 : old u of the row being updated (to neighbours)
//   left_u, right_u           : neighbours' old u of the same row
//   tap_out                   : registered new u[TAP_ROW]
// Build option DRUM_CLAMP_EN (in drum_node_update): saturating instead of wrapping update.
module drum_column_solver
    import drum_pkg::*;
#(
    parameter int unsigned WIDTH           = DefaultWidth,
    parameter int unsigned ROWS            = DefaultRows,
    parameter int unsigned RHO_SHIFT       = 4,
    parameter int unsigned DAMP_PREV_SHIFT = 12,
    parameter int unsigned DAMP_OUT_SHIFT  = 13,
    parameter int unsigned TAP_ROW         = ROWS / 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_we,
    input  logic [$clog2(ROWS)-1:0] init_addr,
    input  logic [WIDTH-1:0]        init_u,
    input  logic [WIDTH-1:0]        init_u_prev,
    input  logic                    step_start,
    output logic                    busy,
    output logic                    step_done,
    output logic [WIDTH-1:0]        u_row_out,
    input  logic [WIDTH-1:0]        left_u,
    input  logic [WIDTH-1:0]        right_u,
    output logic [WIDTH-1:0]        tap_out
);

    localparam int unsigned   AW         = $clog2(ROWS);
    localparam logic [AW-1:0] LastRow    = AW'(ROWS - 1);
    localparam logic [AW-1:0] PreLastRow = AW'(ROWS - 2);
    localparam logic [AW-1:0] TapRow     = AW'(TAP_ROW);

    solver_state_e state_q, state_d;
    logic [AW-1:0] row_q, row_d;

    logic [WIDTH-1:0] u_mem  [ROWS];
    logic [WIDTH-1:0] up_mem [ROWS];

    logic [WIDTH-1:0] u_rd_q;       // read-ahead: old u[i+1] during RUN row i
    logic [WIDTH-1:0] up_rd_q;      // old u_prev[i] during RUN row i
    logic [WIDTH-1:0] win_prev_q;   // old u[i-1]
    logic [WIDTH-1:0] win_cur_q;    // old u[i]
    logic [WIDTH-1:0] tap_q;

    logic             u_re, up_re, run_we;
    logic [AW-1:0]    u_raddr, up_raddr;
    logic [WIDTH-1:0] down;
    logic [WIDTH-1:0] u_next;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        u_re      = 1'b0;
        up_re     = 1'b0;
        u_raddr   = '0;
        up_raddr  = '0;
        run_we    = 1'b0;
        busy      = 1'b0;
        step_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (step_start) begin
                    state_d = StLoad0;
                end
            end
            StLoad0: begin
                busy    = 1'b1;
                u_re    = 1'b1;
                u_raddr = '0;
                state_d = StLoad1;
            end
            StLoad1: begin
                busy     = 1'b1;
                u_re     = 1'b1;
                u_raddr  = AW'(1);
                up_re    = 1'b1;
                up_raddr = '0;
                row_d    = '0;
                state_d  = StRun;
            end
            StRun: begin
                busy   = 1'b1;
                run_we = 1'b1;
                // u runs two rows ahead, u_prev one row ahead; nothing past the last row
                if (row_q < PreLastRow) begin
                    u_re    = 1'b1;
                    u_raddr = row_q + AW'(2);
                end
                if (row_q != LastRow) begin
                    up_re    = 1'b1;
                    up_raddr = row_q + AW'(1);
                end
                if (row_q == LastRow) begin
                    state_d = StDone;
                end else begin
                    row_d = row_q + AW'(1);
                end
            end
            StDone: begin
                step_done = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
        down = (row_q == LastRow) ? '0 : u_rd_q;
    end

    drum_node_update #(
        .WIDTH          (WIDTH),
        .RHO_SHIFT      (RHO_SHIFT),
        .DAMP_PREV_SHIFT(DAMP_PREV_SHIFT),
        .DAMP_OUT_SHIFT (DAMP_OUT_SHIFT)
    ) u_node_update (
        .up_i    (win_prev_q),
        .down_i  (down),
        .left_i  (left_u),
        .right_i (right_u),
        .u_i     (win_cur_q),
        .u_prev_i(up_rd_q),
        .u_next_o(u_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            if (run_we && (row_q == TapRow)) begin
                tap_q <= u_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StLoad1) begin
            win_prev_q <= '0;
            win_cur_q  <= u_rd_q;
        end else if (run_we) begin
            win_prev_q <= win_cur_q;
            win_cur_q  <= down;
        end
        if (u_re) begin
            u_rd_q <= u_mem[u_raddr];
        end
        if (up_re) begin
            up_rd_q <= up_mem[up_raddr];
        end
    end

    // A reset in the cycle of a row's update suppresses that row's write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_we && (state_q == StIdle)) begin
                u_mem[init_addr]  <= init_u;
                up_mem[init_addr] <= init_u_prev;
            end else if (run_we) begin
                u_mem[row_q]  <= u_next;
                up_mem[row_q] <= win_cur_q;
            end
        end
    end

    assign u_row_out = (state_q == StRun) ? win_cur_q : '0;
    assign tap_out   = tap_q;

endmodule

// File: tb/tb_drum_column_solver.sv
// tb_drum_column_solver: directed bench for drum_column_solver (WIDTH=18, ROWS=4, TAP_ROW=1).
// A column-level integer model predicts busy/step_done/u_row_out/tap_out every cycle.
module tb_drum_column_solver;

    localparam int W   = 18;
    localparam int R   = 4;
    localparam int TAP = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init_we = 1'b0;
    logic [1:0]   init_addr = '0;
    logic [W-1:0] init_u = '0;
    logic [W-1:0] init_u_prev = '0;
    logic         step_start = 1'b0;
    logic         busy;
    logic         step_done;
    logic [W-1:0] u_row_out;
    logic [W-1:0] left_u = '0;
    logic [W-1:0] right_u = '0;
    logic [W-1:0] tap_out;

    always #5 clk = ~clk;

    drum_column_solver #(
        .WIDTH  (W),
        .ROWS   (R),
        .TAP_ROW(TAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_u     (init_u),
        .init_u_prev(init_u_prev),
        .step_start (step_start),
        .busy       (busy),
        .step_done  (step_done),
        .u_row_out  (u_row_out),
        .left_u     (left_u),
        .right_u    (right_u),
        .tap_out    (tap_out)
    );

    int m_u [R];
    int m_up[R];
    int lv  [R];
    int rv  [R];
    int nu  [R];

    int exp_busy = 0;
    int exp_done = 0;
    int exp_row  = 0;
    int exp_tap  = 0;
    bit chk_en   = 1'b0;
    int n_pass   = 0;
    int n_total  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), exp_busy);
            check("step_done", int'(step_done), exp_done);
            check("u_row_out", int'($signed(u_row_out)), exp_row);
            check("tap_out", int'($signed(tap_out)), exp_tap);
        end
    end

    function automatic int fit(input int x);
        int m;
`ifdef DRUM_CLAMP_EN
        if (x > (1 << (W - 1)) - 1) return (1 << (W - 1)) - 1;
        if (x < -(1 << (W - 1))) return -(1 << (W - 1));
        return x;
`else
        m = x & ((1 << W) - 1);
        if (m >= (1 << (W - 1))) m = m - (1 << W);
        return m;
`endif
    endfunction

    // New column from the damped wave equation, edges clamped to 0.
    task automatic model_step();
        int up, dn, lap, r, t;
        for (int i = 0; i < R; i++) begin
            up  = (i == 0) ? 0 : m_u[i-1];
            dn  = (i == R - 1) ? 0 : m_u[i+1];
            lap = up + dn + lv[i] + rv[i] - 4 * m_u[i];
            r   = lap >>> 4;
            t   = fit(r + 2 * m_u[i] - m_up[i] + (m_up[i] >>> 12));
            nu[i] = fit(t - (t >>> 13));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            step_start = 1'b0;
            init_we    = 1'b0;
            left_u     = '0;
            right_u    = '0;
            exp_busy   = 0;
            exp_done   = 0;
            exp_row    = 0;
        end
    endtask

    task automatic load(input int a, input int u, input int up);
        idle(1);
        init_we     = 1'b1;
        init_addr   = 2'(a);
        init_u      = W'(u);
        init_u_prev = W'(up);
        m_u[a]      = u;
        m_up[a]     = up;
    endtask

    // rst_at: step cycle (1..) in which rst is asserted, 0 for none.
    // poke: pulse step_start and init_we in the first RUN cycle.
    task automatic do_step(input int rst_at, input bit poke);
        bit aborted;
        aborted = 1'b0;
        model_step();
        idle(1);
        step_start = 1'b1;
        for (int p = 1; p <= R + 3; p++) begin
            tick();
            step_start = 1'b0;
            init_we    = 1'b0;
            left_u     = '0;
            right_u    = '0;
            if (aborted) begin
                rst      = 1'b0;
                exp_busy = 0;
                exp_done = 0;
                exp_row  = 0;
                exp_tap  = 0;
                break;
            end
            exp_busy = (p <= R + 2) ? 1 : 0;
            exp_done = (p == R + 3) ? 1 : 0;
            exp_row  = (p >= 3 && p <= R + 2) ? m_u[p-3] : 0;
            if (p == 4 + TAP) exp_tap = nu[TAP];
            if (p >= 3 && p <= R + 2) begin
                left_u  = W'(lv[p-3]);
                right_u = W'(rv[p-3]);
            end
            if (poke && p == 3) begin
                step_start  = 1'b1;
                init_we     = 1'b1;
                init_addr   = 2'd2;
                init_u      = W'(5000);
                init_u_prev = W'(7);
            end
            if (p == rst_at) begin
                rst     = 1'b1;
                aborted = 1'b1;
            end
        end
        for (int i = 0; i < R; i++) begin
            if (!aborted || (i + 3 < rst_at)) begin
                m_up[i] = m_u[i];
                m_u[i]  = nu[i];
            end
        end
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < R; i++) begin
            lv[i] = 0;
            rv[i] = 0;
        end
        tick();
        chk_en = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // All-zero column stays zero; timing checked cycle by cycle.
        for (int i = 0; i < R; i++) load(i, 0, 0);
        do_step(0, 1'b0);

        // Single excited node.
        load(1, 16384, 16384);
        do_step(0, 1'b0);
        check("lit_tap_12291", int'($signed(tap_out)), 12291);
        check("lit_model_u0", m_u[0], 1024);
        check("lit_model_u1", m_u[1], 12291);
        check("lit_model_u2", m_u[2], 1024);
        check("lit_model_u3", m_u[3], 0);
        check("lit_model_up1", m_up[1], 16384);
        do_step(0, 1'b0);   // reads back the previous step via u_row_out

        // Start/init pulses while busy are ignored.
        do_step(0, 1'b1);
        do_step(0, 1'b0);

        // Reset mid-step, then a fresh step.
        do_step(4, 1'b0);
        do_step(0, 1'b0);

        // Full-scale column with full-scale neighbours.
        for (int i = 0; i < R; i++) begin
            load(i, 131071, 0);
            lv[i] = 131071;
            rv[i] = 131071;
        end
        do_step(0, 1'b0);
`ifdef DRUM_CLAMP_EN
        check("lit_tap_full", int'($signed(tap_out)), 131056);
`else
        check("lit_tap_full", int'($signed(tap_out)), -1);
`endif
        do_step(0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
